// File: rtl/lock_code_sequencer.sv
// Upstream driver for a serial combination-lock FSM: clears the lock, shifts a code
// word out MSB-first, then watches UNLK and reports PASS/FAIL with a one-cycle DONE.
module lock_code_sequencer #(
  parameter int CODE_W    = 8,
  parameter int RESP_WAIT = 4
) (
  input  logic              CLK,
  input  logic              CLR_L,
  input  logic              START,
  input  logic [CODE_W-1:0] CODE,
  input  logic              UNLK,
  output logic              LOCK_CLR,
  output logic              X,
  output logic              X_VLD,
  output logic              BUSY,
  output logic              DONE,
  output logic              PASS
);

  localparam int CNT_W  = $clog2(CODE_W);
  localparam int WCNT_W = $clog2(RESP_WAIT + 1);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CODE_W - 1);
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(RESP_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SHIFT,
    S_WAIT,
    S_REPORT
  } state_e;

  state_e              state_q, state_d;
  logic [CODE_W-1:0]   sreg_q, sreg_d;
  logic [CNT_W-1:0]    bcnt_q, bcnt_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic                pass_q, pass_d;
  logic                x_q, x_d;
  logic                lock_clr_q, x_vld_q, busy_q, done_q;

  // NOTE: every variable gets its default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    bcnt_d  = bcnt_q;
    wcnt_d  = wcnt_q;
    pass_d  = pass_q;
    x_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          sreg_d  = CODE;
          pass_d  = 1'b0;
          bcnt_d  = '0;
          wcnt_d  = '0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        // Outputs are registered, so the first bit is loaded on the way into SHIFT.
        x_d     = sreg_q[CODE_W-1];
        sreg_d  = sreg_q << 1;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        sreg_d = sreg_q << 1;
        if (bcnt_q == BIT_LAST) begin
          state_d = S_WAIT;
        end else begin
          bcnt_d = bcnt_q + CNT_W'(1);
          x_d    = sreg_q[CODE_W-1];
        end
      end
      S_WAIT: begin
        if (UNLK) begin
          pass_d  = 1'b1;
          state_d = S_REPORT;
        end else if (wcnt_q == WAIT_LAST) begin
          state_d = S_REPORT;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      S_REPORT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge CLR_L) begin
    if (!CLR_L) begin
      state_q    <= S_IDLE;
      sreg_q     <= '0;
      bcnt_q     <= '0;
      wcnt_q     <= '0;
      pass_q     <= 1'b0;
      x_q        <= 1'b0;
      lock_clr_q <= 1'b0;
      x_vld_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      bcnt_q     <= bcnt_d;
      wcnt_q     <= wcnt_d;
      pass_q     <= pass_d;
      x_q        <= x_d;
      lock_clr_q <= (state_d == S_CLEAR);
      x_vld_q    <= (state_d == S_SHIFT);
      busy_q     <= (state_d != S_IDLE);
      done_q     <= (state_d == S_REPORT);
    end
  end

  assign LOCK_CLR = lock_clr_q;
  assign X        = x_q;
  assign X_VLD    = x_vld_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign PASS     = pass_q;

endmodule

// File: tb/tb_lock_code_sequencer.sv
// Bench for lock_code_sequencer: directed scenarios plus randomized attempts on an
// 8-bit and a 4-bit instance, each checked cycle by cycle against a waveform model.
module tb_lock_code_sequencer;

  localparam int RW = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       unlk = 1'b0;
  logic       start8 = 1'b0, start4 = 1'b0;
  logic [7:0] code8 = '0;
  logic [3:0] code4 = '0;
  logic       lc8, x8, v8, b8, d8, p8;
  logic       lc4, x4, v4, b4, d4, p4;
  bit         sel = 1'b0;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  lock_code_sequencer #(.CODE_W(8), .RESP_WAIT(RW)) dut8 (
    .CLK(clk), .CLR_L(rst_n), .START(start8), .CODE(code8), .UNLK(unlk),
    .LOCK_CLR(lc8), .X(x8), .X_VLD(v8), .BUSY(b8), .DONE(d8), .PASS(p8)
  );

  lock_code_sequencer #(.CODE_W(4), .RESP_WAIT(RW)) dut4 (
    .CLK(clk), .CLR_L(rst_n), .START(start4), .CODE(code4), .UNLK(unlk),
    .LOCK_CLR(lc4), .X(x4), .X_VLD(v4), .BUSY(b4), .DONE(d4), .PASS(p4)
  );

  // Output vector order: {LOCK_CLR, X, X_VLD, BUSY, DONE, PASS}
  wire [5:0] o8  = {lc8, x8, v8, b8, d8, p8};
  wire [5:0] o4  = {lc4, x4, v4, b4, d4, p4};
  wire [5:0] obs = sel ? o4 : o8;

  // One attempt. Offset n counts clock edges after the accepting edge; outputs are
  // sampled 1 time unit after each edge and UNLK[n] is held until the following edge.
  task automatic run_attempt(input string name, input bit use4, input logic [7:0] code,
                             input logic [31:0] pat, input bit disturb);
    int         w;
    int         d_off;
    bit         exp_pass;
    bit         found;
    logic [5:0] exp;
    w        = use4 ? 4 : 8;
    sel      = use4;
    d_off    = w + 1 + RW;
    exp_pass = 1'b0;
    found    = 1'b0;
    for (int n = w + 1; n <= w + RW; n++) begin
      if (!found && pat[n]) begin
        found    = 1'b1;
        exp_pass = 1'b1;
        d_off    = n + 1;
      end
    end

    if (use4) begin start4 = 1'b1; code4 = code[3:0]; end
    else      begin start8 = 1'b1; code8 = code;      end
    @(posedge clk); #1;

    for (int n = 0; n <= d_off + 1; n++) begin
      exp[5] = (n == 0);
      exp[3] = (n >= 1 && n <= w);
      exp[4] = exp[3] ? code[w - n] : 1'b0;
      exp[2] = (n <= d_off);
      exp[1] = (n == d_off);
      exp[0] = (n >= d_off) ? exp_pass : 1'b0;
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL %s n=%0d got=%b want=%b", name, n, obs, exp);
      end
      if (n == d_off + 1) break;
      // Junk on CODE, START in SHIFT and in REPORT must all be ignored while busy.
      if (use4) begin
        start4 = disturb && (n == 4 || n == d_off);
        code4  = (disturb && n == 3) ? 4'hF : 4'($urandom);
      end else begin
        start8 = disturb && (n == 4 || n == d_off);
        code8  = (disturb && n == 4) ? 8'hFF : 8'($urandom);
      end
      unlk = pat[n];
      @(posedge clk); #1;
    end
    start8 = 1'b0;
    start4 = 1'b0;
    unlk   = 1'b0;
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #1;
    total += 2;
    if (o8 !== 6'b0) begin bad++; $display("FAIL reset8 got=%b want=000000", o8); end
    if (o4 !== 6'b0) begin bad++; $display("FAIL reset4 got=%b want=000000", o4); end
    #19 rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (o8 !== 6'b0) begin bad++; $display("FAIL reset_idle got=%b want=000000", o8); end
  endtask

  task automatic test_pass();
    run_attempt("pass", 1'b0, 8'h6E, 32'h1 << 9, 1'b0);
  endtask

  task automatic test_fail();
    run_attempt("fail", 1'b0, 8'h6E, 32'h0, 1'b0);
  endtask

  task automatic test_ignore();
    run_attempt("ignore", 1'b0, 8'h6E, 32'h1 << 10, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_attempt("b2b", 1'b0, 8'hA5, 32'h1 << 12, 1'b0);
  endtask

  task automatic test_abort();
    sel    = 1'b0;
    start8 = 1'b1;
    code8  = 8'h6E;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    total++;
    if (o8 !== 6'b011100) begin bad++; $display("FAIL abort_pre got=%b want=011100", o8); end
    #2 rst_n = 1'b0;
    #1;
    total += 2;
    if (o8 !== 6'b0) begin bad++; $display("FAIL abort8 got=%b want=000000", o8); end
    if (o4 !== 6'b0) begin bad++; $display("FAIL abort4 got=%b want=000000", o4); end
    repeat (3) begin
      @(posedge clk); #1;
      total++;
      if (o8 !== 6'b0) begin bad++; $display("FAIL abort_hold got=%b want=000000", o8); end
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      total++;
      if (d8 !== 1'b0) begin bad++; $display("FAIL abort_nodone got=%b want=0", d8); end
    end
    run_attempt("abort_retry", 1'b0, 8'h6E, 32'h1 << 9, 1'b0);
  endtask

  task automatic test_width();
    run_attempt("width", 1'b1, 8'h0B, 32'h1 << 6, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      bit          use4;
      int          w;
      logic [31:0] pat;
      use4 = 1'($urandom);
      w    = use4 ? 4 : 8;
      pat  = $urandom;
      for (int n = w + 1; n <= w + RW; n++) pat[n] = 1'b0;
      if ($urandom_range(0, 2) != 0) pat[w + 1 + $urandom_range(0, RW - 1)] = 1'b1;
      run_attempt("random", use4, 8'($urandom), pat, 1'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_ignore();
    test_back_to_back();
    test_abort();
    test_width();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
